// File: rtl/weight_loader.sv
// Weight-tile sequencer: preloads rows into the systolic array, then issues the swap pulse.
// Define WEIGHT_LOADER_ZERO_FILL_EN to zero-preload rows beyond num_rows so stale weights never survive.
module weight_loader #(
    parameter int MATRIX_WIDTH        = 14,
    parameter int EXTENDED_BYTE_WIDTH = 16,
    localparam int RW                 = $clog2(MATRIX_WIDTH + 1)
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic [RW-1:0]                               num_rows,
    input  logic [MATRIX_WIDTH*EXTENDED_BYTE_WIDTH-1:0] weight_row_in,
    input  logic                                        weight_row_valid,
    output logic                                        weight_row_ready,
    output logic [MATRIX_WIDTH*EXTENDED_BYTE_WIDTH-1:0] weight_out,
    output logic [MATRIX_WIDTH-1:0]                     preload_weight,
    input  logic                                        swap_allow,
    output logic                                        load_weight,
    output logic                                        busy,
    output logic                                        done
);
    localparam int ROW_W = MATRIX_WIDTH * EXTENDED_BYTE_WIDTH;
    localparam logic [RW-1:0] FULL = RW'(MATRIX_WIDTH);

    // The swap cycle is the first IDLE cycle, marked by the registered load pulse,
    // so a new start is accepted in the same cycle as load_weight/done.
    typedef enum logic [1:0] {
        IDLE,
        PRELOAD,
        WAIT_SWAP
    } state_t;

    state_t                  state_reg, state_next;
    logic [RW-1:0]           r_reg, r_next;
    logic [RW-1:0]           k_reg, k_next;
    logic [RW-1:0]           r_inc;
    logic [ROW_W-1:0]        weight_out_reg, weight_out_next;
    logic [MATRIX_WIDTH-1:0] preload_reg, preload_next;
    logic [MATRIX_WIDTH-1:0] row_onehot;
    logic                    load_reg, load_next;
    logic                    rows_left;

    for (genvar gi = 0; gi < MATRIX_WIDTH; gi++) begin : g_onehot
        assign row_onehot[gi] = (r_reg == RW'(gi));
    end

    assign r_inc     = r_reg + RW'(1);
    assign rows_left = (r_reg < k_reg);

    assign weight_row_ready = (state_reg == PRELOAD) && rows_left;
    assign busy             = (state_reg != IDLE);
    assign weight_out       = weight_out_reg;
    assign preload_weight   = preload_reg;
    assign load_weight      = load_reg;
    assign done             = load_reg;

    always_comb begin
        state_next      = state_reg;
        r_next          = r_reg;
        k_next          = k_reg;
        weight_out_next = weight_out_reg;
        preload_next    = '0;
        load_next       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    k_next     = (num_rows > FULL) ? FULL : num_rows;
                    r_next     = '0;
                    state_next = PRELOAD;
                end
            end
            PRELOAD: begin
                if (rows_left) begin
                    if (weight_row_valid) begin
                        weight_out_next = weight_row_in;
                        preload_next    = row_onehot;
                        r_next          = r_inc;
`ifdef WEIGHT_LOADER_ZERO_FILL_EN
                        if (r_inc == FULL) state_next = WAIT_SWAP;
`else
                        if (r_inc == k_reg) state_next = WAIT_SWAP;
`endif
                    end
                end else begin
`ifdef WEIGHT_LOADER_ZERO_FILL_EN
                    weight_out_next = '0;
                    preload_next    = row_onehot;
                    r_next          = r_inc;
                    if (r_inc == FULL) state_next = WAIT_SWAP;
`else
                    // Only reachable with an empty tile: nothing to preload.
                    state_next = WAIT_SWAP;
`endif
                end
            end
            WAIT_SWAP: begin
                if (swap_allow) begin
                    load_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            r_reg          <= '0;
            k_reg          <= '0;
            weight_out_reg <= '0;
            preload_reg    <= '0;
            load_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            r_reg          <= r_next;
            k_reg          <= k_next;
            weight_out_reg <= weight_out_next;
            preload_reg    <= preload_next;
            load_reg       <= load_next;
        end
    end
endmodule
